// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Single-slot instruction fetch stage. It tracks the fetch PC,
//               issues one request per cycle to instruction memory and holds
//               the returned word in a one-entry output register.
//               Optional macro FETCH_MISALIGN_TRAP_EN adds a TRAP state and a
//               fetch_misalign output that flag misaligned redirect targets.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        w_slot_free;
    logic        w_req;
    logic        w_load;

    // A FULL stage with stall dropped behaves as FETCH in that same cycle,
    // which is what keeps the release-to-next-word latency at one cycle.
    always_comb begin
        w_slot_free = !if_valid_q || !stall;
        w_req       = rst_n && !redirect && (state_q != TRAP) && w_slot_free;
        w_load      = w_req && imem_ack;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        if (redirect) begin
            if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                pc_d    = redirect_pc;
                state_d = TRAP;
            end else begin
                pc_d    = redirect_pc;
                state_d = FETCH;
            end
`else
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            state_d = FETCH;
`endif
        end else if (state_q == TRAP) begin
            state_d = TRAP;
        end else begin
            if (w_load) begin
                if_inst_d  = imem_rdata;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
                pc_d       = pc_q + 32'd4;
            end else if (!stall) begin
                if_valid_d = 1'b0;
            end
            state_d = (if_valid_q && stall) ? FULL : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_inst_q  <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = (state_q == TRAP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios with
//               literal expectations followed by randomized traffic checked
//               against a behavioural model of the fetch stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_misalign;

    logic        echo;
    logic [31:0] rnd_rdata;

    assign imem_rdata = echo ? imem_addr : rnd_rdata;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Behavioural model: architectural view of the stage
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifinst;
    logic        m_trap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0000_0000;
        m_valid  = 1'b0;
        m_ifpc   = 32'h0000_0000;
        m_ifinst = 32'h0000_0013;
        m_trap   = 1'b0;
    endtask

    function automatic logic model_req();
        return rst_n && !m_trap && !redirect && (!m_valid || !stall);
    endfunction

    task automatic settle_check();
        #1;
        chk("imem_req",  {31'd0, imem_req}, {31'd0, model_req()});
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid",  {31'd0, if_valid}, {31'd0, m_valid});
        chk("if_pc",     if_pc, m_ifpc);
        chk("if_inst",   if_inst, m_ifinst);
        chk("misalign",  {31'd0, fetch_misalign}, {31'd0, m_trap});
    endtask

    task automatic edge_step();
        logic req;
        logic [31:0] word;
        req  = model_req();
        word = echo ? m_pc : rnd_rdata;
        @(posedge clk);
        if (rst_n) begin
            if (redirect) begin
                m_valid = 1'b0;
                if (TRAP_EN && redirect_pc[1:0] != 2'b00) begin
                    m_trap = 1'b1;
                    m_pc   = redirect_pc;
                end else begin
                    m_trap = 1'b0;
                    m_pc   = {redirect_pc[31:2], 2'b00};
                end
            end else if (req && imem_ack) begin
                m_ifinst = word;
                m_ifpc   = m_pc;
                m_valid  = 1'b1;
                m_pc     = m_pc + 32'd4;
            end else if (!stall) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cycle();
        settle_check();
        edge_step();
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        echo        = 1'b1;
        rnd_rdata   = 32'h0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        imem_ack = 1'b1;
        settle_check();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_inst",  if_inst, 32'h0000_0013);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        rst_n = 1'b1;

        // Streaming with ack every cycle
        settle_check();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        edge_step();
        chk("stream_pc0", if_pc, 32'd0);
        chk("stream_v0", {31'd0, if_valid}, 32'd1);
        cycle();
        chk("stream_pc4", if_pc, 32'd4);
        cycle();
        chk("stream_pc8", if_pc, 32'd8);
        chk("stream_inst8", if_inst, 32'd8);

        // Stall holds the slot
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            edge_step();
            chk("stall_pc", if_pc, 32'd8);
            chk("stall_inst", if_inst, 32'd8);
        end
        stall = 1'b0;
        cycle();
        chk("unstall_pc12", if_pc, 32'd12);

        // Memory wait at pc=16
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle_check();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'd16);
            edge_step();
            chk("wait_valid", {31'd0, if_valid}, 32'd0);
        end
        imem_ack = 1'b1;
        cycle();
        chk("wait_pc16", if_pc, 32'd16);

        // Redirect coincident with ack drops the word
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0;
        cycle();
        chk("redir_pc", if_pc, 32'h100);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        settle_check();
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned redirect
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        edge_step();
        redirect = 1'b0;
        settle_check();
        if (TRAP_EN) begin
            chk("trap_flag", {31'd0, fetch_misalign}, 32'd1);
            chk("trap_req", {31'd0, imem_req}, 32'd0);
            edge_step();
            cycle();
            chk("trap_hold", {31'd0, if_valid}, 32'd0);
            redirect    = 1'b1;
            redirect_pc = 32'h200;
            cycle();
            redirect = 1'b0;
            settle_check();
            chk("trap_exit_req", {31'd0, imem_req}, 32'd1);
            chk("trap_exit_addr", imem_addr, 32'h200);
            edge_step();
            chk("trap_exit_pc", if_pc, 32'h200);
        end else begin
            chk("align_addr", imem_addr, 32'h100);
            edge_step();
            chk("align_pc", if_pc, 32'h100);
        end

        // Reset while a fetch is pending
        imem_ack = 1'b0;
        settle_check();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid", {31'd0, if_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        cycle();
        chk("midrst_pc0", if_pc, 32'd0);
        chk("midrst_inst0", if_inst, 32'd0);

        // Randomized traffic
        echo = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            stall     = ($urandom_range(0, 99) < 30);
            imem_ack  = ($urandom_range(0, 99) < 60);
            redirect  = ($urandom_range(0, 99) < 8);
            rnd_rdata = $urandom;
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                default: redirect_pc = $urandom & 32'h0000_FFFC;
            endcase
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
